// File: rtl/trail_fb_scheduler_if.sv
// Frame-buffer write port between the trail scheduler (master) and the memory controller (slave).
interface trail_fb_scheduler_if;
    logic [19:0] fb_addr;
    logic [15:0] fb_wdata;
    logic        fb_we;
    logic        fb_gnt;

    modport master (output fb_addr, output fb_wdata, output fb_we, input fb_gnt);
    modport slave  (input fb_addr, input fb_wdata, input fb_we, output fb_gnt);
endinterface

// File: rtl/trail_fb_scheduler.sv
// Sequences frame-buffer clears and per-frame trail blocks for both bikes onto one SRAM write port.
// Optional macro TRAIL_4X4_EN widens each player block from 2x2 to 4 rows x 2 columns.
module trail_fb_scheduler #(
    parameter int          FB_W      = 320,
    parameter int          FB_DEPTH  = 307200,
    parameter int          X_OFS     = 8,
    parameter logic [15:0] BLUE_CODE = 16'h0001,
    parameter logic [15:0] RED_CODE  = 16'h0003
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_clk,
    input  logic [2:0]                   Game_State,
    input  logic [7:0]                   Blue_X,
    input  logic [7:0]                   Blue_Y,
    input  logic [7:0]                   Red_X,
    input  logic [7:0]                   Red_Y,
    trail_fb_scheduler_if.master         fb,
    output logic                         busy,
    output logic [7:0]                   overrun_cnt
);
    localparam logic [2:0] PLAY = 3'b010;
`ifdef TRAIL_4X4_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif
    localparam logic [IDX_W-1:0] IDX_LAST   = '1;
    localparam logic [19:0]      CLEAR_LAST = 20'(FB_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FIRST, SECOND} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next, idx_inc;
    logic [19:0]       addr_reg, addr_next;
    logic [15:0]       wdata_reg, wdata_next;
    logic              we_reg, we_next;
    logic              busy_reg;
    logic [7:0]        overrun_reg;
    logic              overrun_inc;
    logic              frame_sync_reg, frame_prev_reg;
    logic [2:0]        gs_prev_reg;
    logic              toggle_reg, toggle_next;       // 1: blue goes first on the next serviced frame
    logic              first_blue_reg, first_blue_next;
    logic              latch_en;
    logic              frame_edge, is_play, play_entry, granted;
    logic [7:0]        coord_in  [4];
    logic [7:0]        coord_lat [4];
    logic [7:0]        live_x, live_y, cur_x, cur_y, sec_x, sec_y;
    logic              cur_blue;

    // Word idx: low bits select the row, top bit selects the column.
    function automatic logic [19:0] word_addr(input logic [7:0] x, input logic [7:0] y,
                                              input logic [IDX_W-1:0] idx);
        logic [19:0] base;
        base = ((20'(x) + 20'(X_OFS)) << 1) + 20'(y) * 20'(FB_W * 4);
        return base + 20'(idx[IDX_W-2:0]) * 20'(FB_W) + 20'(idx[IDX_W-1]);
    endfunction

    assign coord_in[0] = Blue_X;
    assign coord_in[1] = Blue_Y;
    assign coord_in[2] = Red_X;
    assign coord_in[3] = Red_Y;

    for (genvar gi = 0; gi < 4; gi++) begin : g_coord
        logic [7:0] coord_q;
        always_ff @(posedge Clk) begin
            if (Reset)         coord_q <= '0;
            else if (latch_en) coord_q <= coord_in[gi];
        end
        assign coord_lat[gi] = coord_q;
    end

    assign frame_edge = frame_sync_reg & ~frame_prev_reg;
    assign is_play    = (Game_State == PLAY);
    assign play_entry = is_play && (gs_prev_reg != PLAY);
    assign granted    = we_reg & fb.fb_gnt;
    assign idx_inc    = idx_reg + 1'b1;

    assign cur_blue = (state_reg == FIRST) ? first_blue_reg : ~first_blue_reg;
    assign live_x   = toggle_reg ? Blue_X : Red_X;
    assign live_y   = toggle_reg ? Blue_Y : Red_Y;
    assign cur_x    = cur_blue ? coord_lat[0] : coord_lat[2];
    assign cur_y    = cur_blue ? coord_lat[1] : coord_lat[3];
    assign sec_x    = first_blue_reg ? coord_lat[2] : coord_lat[0];
    assign sec_y    = first_blue_reg ? coord_lat[3] : coord_lat[1];

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        we_next         = we_reg;
        toggle_next     = toggle_reg;
        first_blue_next = first_blue_reg;
        latch_en        = 1'b0;
        overrun_inc     = 1'b0;
        case (state_reg)
            IDLE: begin
                we_next = 1'b0;
                if (play_entry) begin
                    // A frame edge colliding with the clear trigger is lost.
                    state_next  = CLEAR;
                    addr_next   = '0;
                    wdata_next  = '0;
                    we_next     = 1'b1;
                    overrun_inc = frame_edge;
                end else if (frame_edge && is_play) begin
                    state_next      = FIRST;
                    idx_next        = '0;
                    latch_en        = 1'b1;
                    first_blue_next = toggle_reg;
                    toggle_next     = ~toggle_reg;
                    addr_next       = word_addr(live_x, live_y, '0);
                    wdata_next      = toggle_reg ? BLUE_CODE : RED_CODE;
                    we_next         = 1'b1;
                end
            end
            CLEAR: begin
                overrun_inc = frame_edge;
                if (granted) begin
                    if (addr_reg == CLEAR_LAST) begin
                        state_next = IDLE;
                        we_next    = 1'b0;
                    end else begin
                        addr_next = addr_reg + 20'd1;
                    end
                end
            end
            default: begin
                overrun_inc = frame_edge;
                if (!is_play) begin
                    state_next = IDLE;
                    we_next    = 1'b0;
                end else if (granted) begin
                    if (idx_reg != IDX_LAST) begin
                        idx_next  = idx_inc;
                        addr_next = word_addr(cur_x, cur_y, idx_inc);
                    end else if (state_reg == FIRST) begin
                        state_next = SECOND;
                        idx_next   = '0;
                        addr_next  = word_addr(sec_x, sec_y, '0);
                        wdata_next = first_blue_reg ? RED_CODE : BLUE_CODE;
                    end else begin
                        state_next = IDLE;
                        we_next    = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            overrun_reg    <= '0;
            frame_sync_reg <= 1'b0;
            frame_prev_reg <= 1'b0;
            gs_prev_reg    <= '0;
            toggle_reg     <= 1'b1;
            first_blue_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            we_reg         <= we_next;
            busy_reg       <= (state_next != IDLE);
            frame_sync_reg <= frame_clk;
            frame_prev_reg <= frame_sync_reg;
            gs_prev_reg    <= Game_State;
            toggle_reg     <= toggle_next;
            first_blue_reg <= first_blue_next;
            if (overrun_inc && (overrun_reg != 8'hFF))
                overrun_reg <= overrun_reg + 8'd1;
        end
    end

    assign fb.fb_addr  = addr_reg;
    assign fb.fb_wdata = wdata_reg;
    assign fb.fb_we    = we_reg;
    assign busy        = busy_reg;
    assign overrun_cnt = overrun_reg;
endmodule
